ram_rmw_arbiter: RTL
====================

Name: ram_rmw_arbiter

Overview:
- Shares port A of the 16-bit x 1024 true dual-port single-clock RAM between two requesters.
- Each request is either a plain read or a read-modify-write (RMW) that adds an operand to a RAM word.
- Replaces hard-coded read/modify/write/re-read sequencers with one round-robin arbitrated engine.
- Returns the read or written value to the winning requester.

Parameters:
- AW, 10, RAM address width.
- DW, 16, RAM data width.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has a request
- req0_ready  out  1  requester 0 request accepted this cycle
- req0_addr  in  AW  requester 0 target address
- req0_op  in  1  0 = read, 1 = RMW add
- req0_operand  in  DW  RMW addend (ignored for read)
- req1_valid, req1_ready, req1_addr, req1_op, req1_operand  as requester 0, for requester 1
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  1  requester index of the response
- rsp_data  out  DW  read value (read) or written value (RMW)
- rsp_err  out  1  write-back verify mismatch (see Optional Feature)
- ram_addr  out  AW  to RAM addr_a
- ram_data  out  DW  to RAM data_a
- ram_we  out  1  to RAM we_a
- ram_q  in  DW  from RAM q_a; registered, valid the cycle after the address is sampled
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE.
  - All outputs 0: req*_ready, rsp_valid, rsp_id, rsp_data, rsp_err, ram_we, ram_addr, ram_data, busy.
  - Round-robin pointer last_grant = 1, so req0 wins first.
- Reset mid-operation: the in-flight op is dropped with no response, and ram_we deasserts immediately.
- States: IDLE, RD, WT, WR, VRD, VCMP, RSP. VRD and VCMP exist only with the macro.
- IDLE:
  - reqN_ready is asserted combinationally for the granted requester only.
  - Grant: if one valid, that requester. If both valid, the requester != last_grant.
  - On handshake (valid & ready): latch addr, op, operand and id; update last_grant; go to RD.
  - No valid: stay in IDLE.
- RD: ram_addr = latched addr, ram_we = 0. Next: WT.
- WT: ram_addr held; capture ram_q into data_q.
  - Read op: go to RSP.
  - RMW op: go to WR.
- WR:
  - ram_addr = latched addr, ram_data = data_q + operand, modulo 2^DW (FFFF+1 = 0000, no carry out), ram_we = 1 for exactly this cycle.
  - Store the sum as wdata_q.
  - Next: RSP, or VRD with the macro.
- RSP:
  - rsp_valid = 1 for one cycle.
  - rsp_id = latched id.
  - rsp_data = data_q (read) or wdata_q (RMW).
  - Next: IDLE.
  - rsp_data, rsp_id and rsp_err hold until the next RSP.
- Latency from handshake cycle to rsp_valid:
  - Read: 3 cycles.
  - RMW: 4 cycles.
  - RMW with verify: 6 cycles.
- Throughput: at most one request in flight. ready is never asserted while busy.
- Requester rule: valid and payload stay stable until ready is seen. The arbiter never drops an asserted, ungranted request.
- Port B of the RAM is not driven by this block.
- ram_we is 0 in every state except WR.
- Address range 0..2^AW-1, with no range check.

Optional Feature:
- Macro: RAM_RMW_VERIFY_EN.
- Defined:
  - After WR, go to VRD: ram_addr = latched addr, ram_we = 0.
  - Then VCMP: compare ram_q with wdata_q; rsp_err = 1 if unequal.
  - Then RSP.
  - Read ops skip verify and give rsp_err = 0.
- Undefined:
  - VRD and VCMP are not built.
  - WR goes directly to RSP.
  - rsp_err is tied to 0.

Test Plan:
- RAM[0]=0x0005; req0 read addr 0 -> req0_ready in the handshake cycle, rsp_valid 3 cycles later, rsp_id=0, rsp_data=0x0005, ram_we never asserted.
- RAM[510]=0x0010; req1 RMW addr 510, operand 0x0003 -> one-cycle ram_we with ram_data=0x0013; rsp_data=0x0013, rsp_id=1; a later read of 510 returns 0x0013.
- RAM[1]=0xFFFF; req0 RMW addr 1, operand 0x0002 -> written value and rsp_data=0x0001 (wrap).
- req0 and req1 both held valid continuously with reads of addrs 0 and 1 -> grants alternate req0, req1, req0, req1; no request starves; response ids match the grant order.
- Assert rst=0 during WR of an RMW -> ram_we drops without waiting for clk, no rsp_valid, busy=0; after release the first grant goes to req0.
- With RAM_RMW_VERIFY_EN, testbench RAM model corrupts the write to addr 513 -> rsp_err=1 six cycles after handshake. Clean writes -> rsp_err=0.

Source files
------------

// File: rtl/ram_rmw_arbiter.sv
// Round-robin arbiter sharing RAM port A between two requesters for reads and read-add-write ops.
// Define RAM_RMW_VERIFY_EN to re-read each write-back and flag a mismatch on rsp_err.
module ram_rmw_arbiter #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [AW-1:0] req0_addr,
    input  logic          req0_op,
    input  logic [DW-1:0] req0_operand,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [AW-1:0] req1_addr,
    input  logic          req1_op,
    input  logic [DW-1:0] req1_operand,
    output logic          rsp_valid,
    output logic          rsp_id,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic          ram_we,
    input  logic [DW-1:0] ram_q,
    output logic          busy
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WT   = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
`ifdef RAM_RMW_VERIFY_EN
    localparam logic [2:0] VRD  = 3'd4;
    localparam logic [2:0] VCMP = 3'd5;
`endif
    localparam logic [2:0] RSP  = 3'd6;

    logic [2:0]    state;
    logic          lastGrant;
    logic          opQ;
    logic          idQ;
    logic [AW-1:0] addrQ;
    logic [DW-1:0] operandQ;
    logic [DW-1:0] dataQ;
    logic [DW-1:0] rspDataQ;
    logic          rspIdQ;
    logic          idle;
    logic          grant0;
    logic          grant1;
    logic [DW-1:0] sum;
`ifdef RAM_RMW_VERIFY_EN
    logic [DW-1:0] wdataQ;
    logic          rspErrQ;
`endif

    // On contention the requester that did not win last time gets the grant.
    assign idle   = (state == IDLE);
    assign grant0 = req0_valid & (~req1_valid | lastGrant);
    assign grant1 = req1_valid & (~req0_valid | ~lastGrant);

    assign req0_ready = rst & idle & grant0;
    assign req1_ready = rst & idle & grant1;

    assign sum       = dataQ + operandQ;
    assign ram_we    = (state == WR);
    assign ram_addr  = idle ? '0 : addrQ;
    assign ram_data  = ram_we ? sum : '0;
    assign busy      = ~idle;
    assign rsp_valid = (state == RSP);
    assign rsp_id    = rspIdQ;
    assign rsp_data  = rspDataQ;
`ifdef RAM_RMW_VERIFY_EN
    assign rsp_err   = rspErrQ;
`else
    assign rsp_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            lastGrant <= 1'b1;
            opQ       <= 1'b0;
            idQ       <= 1'b0;
            addrQ     <= '0;
            operandQ  <= '0;
            dataQ     <= '0;
            rspDataQ  <= '0;
            rspIdQ    <= 1'b0;
`ifdef RAM_RMW_VERIFY_EN
            wdataQ    <= '0;
            rspErrQ   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        addrQ     <= grant1 ? req1_addr : req0_addr;
                        opQ       <= grant1 ? req1_op : req0_op;
                        operandQ  <= grant1 ? req1_operand : req0_operand;
                        idQ       <= grant1;
                        lastGrant <= grant1;
                        state     <= RD;
                    end
                end
                RD: state <= WT;
                WT: begin
                    dataQ <= ram_q;
                    if (opQ) begin
                        state <= WR;
                    end else begin
                        // Response registers load on entry to RSP and hold afterwards.
                        rspDataQ <= ram_q;
                        rspIdQ   <= idQ;
`ifdef RAM_RMW_VERIFY_EN
                        rspErrQ  <= 1'b0;
`endif
                        state    <= RSP;
                    end
                end
                WR: begin
`ifdef RAM_RMW_VERIFY_EN
                    wdataQ <= sum;
                    state  <= VRD;
`else
                    rspDataQ <= sum;
                    rspIdQ   <= idQ;
                    state    <= RSP;
`endif
                end
`ifdef RAM_RMW_VERIFY_EN
                VRD: state <= VCMP;
                VCMP: begin
                    rspDataQ <= wdataQ;
                    rspIdQ   <= idQ;
                    rspErrQ  <= (ram_q != wdataQ);
                    state    <= RSP;
                end
`endif
                RSP:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
